ahb_burst_master: RTL and testbench
===================================

// Module: ahb_burst_master
// PURPOSE
// - AHB-lite burst master sitting directly upstream of ahb_slave (drives its hsel/haddr/htrans/hburst/hwrite/hwdata).
// - Converts a simple command/write-data/read-data stream interface into AHB SINGLE/INCRx/WRAPx bursts.
// - Handles the address/data phase pipeline, hready stalls, BUSY insertion and wrap-boundary address arithmetic.
// PARAMETERS
// - ADDR_W  32  address width (byte address)
// - DATA_W  32  data width; hsize fixed to word (3'b010), beat stride 4 bytes
// PORTS
// - hclk         in   1       clock; all logic on rising edge
// - hreset       in   1       asynchronous, active-high reset
// - cmd_valid    in   1       command request
// - cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
// - cmd_write    in   1       1 = write burst, 0 = read burst
// - cmd_addr     in   ADDR_W  start address, word aligned (addr[1:0] ignored)
// - cmd_burst    in   3       AHB hburst encoding of the burst
// - wdata_valid  in   1       write data beat available
// - wdata_ready  out  1       write beat consumed this cycle
// - wdata        in   DATA_W  write data beat
// - rdata_valid  out  1       read beat returned this cycle
// - rdata        out  DATA_W  read data beat
// - rsp_done     out  1       1-cycle pulse: final data phase of burst completed
// - hsel         out  1       slave select; high from NONSEQ through last data phase
// - haddr        out  ADDR_W  AHB address
// - htrans       out  2       AHB transfer type
// - hburst       out  3       AHB burst type
// - hwrite       out  1       AHB direction
// - hsize        out  3       constant 3'b010
// - hwdata       out  DATA_W  AHB write data (registered)
// - hready       in   1       slave ready (ahb_slave hreadyout)
// - hrdata       in   DATA_W  AHB read data
// BEHAVIOUR
// - Reset (async): state IDLE; htrans=IDLE, hsel=0, haddr=0, hburst=0, hwrite=0, hwdata=0, all handshake outs 0.
// - Beats: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16; undefined INCR (3'b001) issued as SINGLE.
// - FSM IDLE -> ADDR -> BURST -> LAST -> IDLE; ADDR goes straight to LAST for 1-beat bursts.
//   IDLE : cmd_ready=1 (write cmd accepted only if wdata_valid also high); on accept latch addr/burst/dir -> ADDR.
//   ADDR : htrans=NONSEQ, haddr=start; on hready -> BURST (beats>1) else LAST.
//   BURST: htrans=SEQ, or BUSY when write && !wdata_valid (haddr held); on hready && SEQ advance address;
//          after last address phase accepted -> LAST.
//   LAST : htrans=IDLE, final data phase; on hready pulse rsp_done -> IDLE. cmd_ready=0 outside IDLE.
// - Handshake: wdata_ready = hwrite && hready && htrans in {NONSEQ,SEQ}; same edge loads hwdata<=wdata.
//   Read: rdata_valid = hready in any read data phase; rdata = hrdata (combinational pass-through).
// - hready low: haddr, htrans, hburst, hwrite, hwdata all held; no counters advance; no handshake pulses.
// - Latency: cmd accept at edge N -> NONSEQ visible cycle N+1; data phase of beat k one cycle after its
//   address phase completes. Minimum one IDLE cycle between bursts (no back-to-back NONSEQ).
// - Address: INCR next = addr+4. WRAPn: mask=(4*n)-1; next = (addr & ~mask) | ((addr+4) & mask).
// - Counters: addr_cnt (address phases accepted) and data_cnt (data phases completed), 5 bits, cleared in IDLE.
// - Reset mid-burst: outputs return to reset values immediately; partial burst is abandoned, no rsp_done.
// STRUCTURE
// - ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_* encodings, HSIZE_WORD, state enum, beats_of(hburst) function.
// - Sub-module ahb_addr_gen: combinational next-address (INCR/WRAP) from addr and hburst.
// TESTING
// - Reset: hreset=1 mid-cycle -> htrans=00, hsel=0 at once; after release cmd_ready=1, htrans=IDLE.
// - SINGLE write 0x10/0xDEADBEEF, hready=1 -> NONSEQ @0x10 cycle 1; hwdata=DEADBEEF, rsp_done cycle 2.
// - INCR4 read 0x100 -> haddr 100,104,108,10C, htrans NONSEQ,SEQ,SEQ,SEQ; 4 rdata_valid pulses; rsp_done.
// - WRAP4 write 0x38 -> haddr 38,3C,30,34; WRAP16 read 0x7C -> 7C,40,44..78.
// - INCR8 write, hready=0 for 2 cycles at beat 3 -> all AHB outputs held; 8 wdata_ready total.
// - INCR4 write, wdata_valid low 1 cycle at beat 2 -> htrans=BUSY, haddr held; SEQ resumes; data order intact.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, master FSM state type and burst-length helpers
// used by the burst master and its address generator.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST
    } state_t;

    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        logic [4:0] n;
        case (burst)
            HBURST_WRAP4, HBURST_INCR4: n = 5'd4;
            HBURST_WRAP8, HBURST_INCR8: n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            default: n = 5'd1;
        endcase
        return n;
    endfunction

    function automatic logic is_wrap(input logic [2:0] burst);
        return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address: +4 for incrementing bursts, and for
// wrapping bursts the low bits roll over inside a (4*beats)-byte window.
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        incr = addr + ADDR_W'(4);
        mask = ADDR_W'({beats_of(burst), 2'b00}) - ADDR_W'(1);
        if (is_wrap(burst)) begin
            next_addr = (addr & ~mask) | (incr & mask);
        end else begin
            next_addr = incr;
        end
    end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-lite burst master: turns a command / write-data / read-data stream
// into SINGLE, INCRx and WRAPx bursts with wait-state and BUSY handling.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rsp_done,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic [DATA_W-1:0] hrdata
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_adv;
    logic [2:0]        burst_reg;
    logic              write_reg;
    logic [DATA_W-1:0] hwdata_reg;
    logic [4:0]        addr_cnt_reg;
    logic [4:0]        data_cnt_reg;
    logic [4:0]        beats;
    logic [1:0]        htrans_q_reg;
    logic              hold_reg;
    logic              cmd_accept;
    logic              phase_acc;
    logic              last_addr;
    logic              data_active;

    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_reg),
        .burst     (burst_reg),
        .next_addr (addr_adv)
    );

    assign beats = beats_of(burst_reg);

    always_comb begin
        htrans     = HTRANS_IDLE;
        cmd_ready  = 1'b0;
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  cmd_ready = !cmd_write || wdata_valid;
            ST_ADDR:  htrans = HTRANS_NONSEQ;
            ST_BURST: begin
                // A wait-stated transfer must keep its type even if wdata_valid moves.
                if (hold_reg) begin
                    htrans = htrans_q_reg;
                end else if (write_reg && !wdata_valid) begin
                    htrans = HTRANS_BUSY;
                end else begin
                    htrans = HTRANS_SEQ;
                end
            end
            default:  htrans = HTRANS_IDLE;
        endcase

        cmd_accept = cmd_valid && cmd_ready;
        phase_acc  = hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        last_addr  = (addr_cnt_reg == beats - 5'd1);

        case (state_reg)
            ST_IDLE: begin
                if (cmd_accept) state_next = ST_ADDR;
            end
            ST_ADDR, ST_BURST: begin
                if (phase_acc) state_next = last_addr ? ST_LAST : ST_BURST;
            end
            ST_LAST: begin
                if (hready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data phase is outstanding whenever more address phases were accepted than completed.
    assign data_active = (addr_cnt_reg != data_cnt_reg);

    assign wdata_ready = write_reg && phase_acc;
    assign rdata_valid = !write_reg && data_active && hready;
    assign rdata       = hrdata;
    assign rsp_done    = (state_reg == ST_LAST) && hready;
    assign hsel        = (state_reg != ST_IDLE);
    assign haddr       = addr_reg;
    assign hburst      = burst_reg;
    assign hwrite      = write_reg;
    assign hsize       = HSIZE_WORD;
    assign hwdata      = hwdata_reg;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            burst_reg    <= HBURST_SINGLE;
            write_reg    <= 1'b0;
            hwdata_reg   <= '0;
            addr_cnt_reg <= '0;
            data_cnt_reg <= '0;
            htrans_q_reg <= HTRANS_IDLE;
            hold_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            htrans_q_reg <= htrans;
            hold_reg     <= (state_reg == ST_BURST) && !hready;

            if (cmd_accept) begin
                addr_reg  <= cmd_addr & ~ADDR_W'(3);
                burst_reg <= (cmd_burst == HBURST_INCR) ? HBURST_SINGLE : cmd_burst;
                write_reg <= cmd_write;
            end else if (phase_acc && (state_next == ST_BURST)) begin
                addr_reg <= addr_adv;
            end

            if (state_reg == ST_IDLE) begin
                addr_cnt_reg <= '0;
                data_cnt_reg <= '0;
            end else begin
                if (phase_acc) addr_cnt_reg <= addr_cnt_reg + 5'd1;
                if (data_active && hready) data_cnt_reg <= data_cnt_reg + 5'd1;
            end

            if (wdata_ready) hwdata_reg <= wdata;
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master: directed bursts push expected address
// phases, data beats and completion records; a negedge monitor pops and compares.
module tb_ahb_burst_master;
    import ahb_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        rsp_done;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic [31:0] hrdata;
    logic [31:0] dp_addr = '0;

    always #5 hclk = ~hclk;

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_burst   (cmd_burst),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rsp_done    (rsp_done),
        .hsel        (hsel),
        .haddr       (haddr),
        .htrans      (htrans),
        .hburst      (hburst),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .hready      (hready),
        .hrdata      (hrdata)
    );

    // Slave read data is a fixed function of the data-phase address.
    assign hrdata = dp_addr ^ KEY;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  burst;
    } aexp_t;

    typedef struct {
        int beats;
        int wr;
        int busy;
        int lat;
    } dexp_t;

    aexp_t       exp_addr[$];
    dexp_t       exp_done[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_rd[$];
    logic [31:0] wq[$];
    logic [31:0] exp_list[$];
    logic [31:0] wd_list[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int nd = 0;
    int nwr = 0;
    int nbusy = 0;
    int nacc = 0;
    int done_cnt = 0;
    int gap_beat = -1;
    int stall_beat = -1;
    int stall_len = 0;
    int stall_left = 0;
    bit ns_chk = 1'b1;
    bit dp_pend = 1'b0;
    bit dp_write = 1'b0;
    bit wr_taken = 1'b0;
    bit gap_now = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s: got %s expected %s", name, act, exp);
    endtask

    initial forever begin
        @(posedge hclk);
        cyc++;
    end

    // Monitor / scoreboard
    initial forever begin
        bit acc;
        dexp_t d;
        @(negedge hclk);
        if (hreset) begin
            dp_pend = 1'b0; nd = 0; nwr = 0; nbusy = 0; nacc = 0; wr_taken = 1'b0;
            continue;
        end
        if (cmd_valid && cmd_ready) begin
            acc_cyc = cyc;
            ns_chk = 1'b0;
        end
        if (dp_pend && hready) begin
            nd++;
            if (dp_write) begin
                if (exp_wd.size() == 0) fail_msg("hwdata_extra", "beat", "none");
                else chk("hwdata", hwdata, exp_wd.pop_front());
            end else begin
                chk("rdata_valid", 32'(rdata_valid), 32'd1);
                if (exp_rd.size() == 0) fail_msg("rdata_extra", "beat", "none");
                else chk("rdata", rdata, exp_rd.pop_front());
            end
        end else begin
            if (rdata_valid) chk("rdata_valid_spurious", 32'(rdata_valid), 32'd0);
            if (dp_pend && dp_write && exp_wd.size() > 0) chk("hwdata_hold", hwdata, exp_wd[0]);
        end
        if (wdata_ready) begin
            nwr++;
            wr_taken = 1'b1;
        end
        if (rsp_done) begin
            if (exp_done.size() == 0) begin
                fail_msg("rsp_done_unexpected", "pulse", "none");
            end else begin
                d = exp_done.pop_front();
                chk("data_beats", 32'(nd), 32'(d.beats));
                chk("wdata_ready_cnt", 32'(nwr), 32'(d.wr));
                chk("busy_cnt", 32'(nbusy), 32'(d.busy));
                chk("done_latency", 32'(cyc - acc_cyc), 32'(d.lat));
                chk("addr_left", 32'(exp_addr.size()), 32'd0);
                $display("burst done: beats=%0d writes=%0d busy=%0d latency=%0d", nd, nwr, nbusy, cyc - acc_cyc);
            end
            nd = 0; nwr = 0; nbusy = 0; nacc = 0;
            done_cnt++;
        end
        acc = 1'b0;
        if (htrans != HTRANS_IDLE) begin
            chk("hsel", 32'(hsel), 32'd1);
            if (exp_addr.size() == 0) begin
                fail_msg("addr_phase_extra", "transfer", "idle");
            end else begin
                chk("haddr", haddr, exp_addr[0].addr);
                if (htrans == HTRANS_BUSY) begin
                    if (hready) nbusy++;
                end else begin
                    chk("htrans", 32'(htrans), 32'(exp_addr[0].trans));
                    chk("hwrite", 32'(hwrite), 32'(exp_addr[0].write));
                    chk("hburst", 32'(hburst), 32'(exp_addr[0].burst));
                    if (htrans == HTRANS_NONSEQ && !ns_chk) begin
                        chk("nonseq_latency", 32'(cyc - acc_cyc), 32'd1);
                        ns_chk = 1'b1;
                    end
                    if (hready) begin
                        void'(exp_addr.pop_front());
                        acc = 1'b1;
                        nacc++;
                    end
                end
            end
        end
        if (hready) begin
            dp_pend = acc;
            if (acc) begin
                dp_write = hwrite;
                dp_addr = haddr;
            end
        end
    end

    // Slave wait-state driver
    initial forever begin
        @(posedge hclk);
        #1;
        if (stall_left > 0) begin
            hready = 1'b0;
            stall_left--;
        end else if (stall_beat >= 0 && htrans == HTRANS_SEQ && nacc == stall_beat) begin
            hready = 1'b0;
            stall_left = stall_len - 1;
            stall_beat = -1;
        end else begin
            hready = 1'b1;
        end
    end

    // Write-data stream driver
    initial forever begin
        @(posedge hclk);
        #1;
        if (wr_taken) begin
            wr_taken = 1'b0;
            if (wq.size() > 0) void'(wq.pop_front());
            if (gap_beat >= 0 && nwr == gap_beat) begin
                gap_now = 1'b1;
                gap_beat = -1;
            end
        end
        if (gap_now) begin
            wdata_valid = 1'b0;
            gap_now = 1'b0;
        end else begin
            wdata_valid = (wq.size() > 0);
            if (wq.size() > 0) wdata = wq[0];
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] b,
                         input logic [2:0] eb, input int busy, input int stall);
        int n;
        bit got;
        aexp_t e;
        dexp_t d;
        n = exp_list.size();
        for (int k = 0; k < n; k++) begin
            e.addr  = exp_list[k];
            e.trans = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            e.write = w;
            e.burst = eb;
            exp_addr.push_back(e);
            if (w) begin
                exp_wd.push_back(wd_list[k]);
                wq.push_back(wd_list[k]);
            end else begin
                exp_rd.push_back(exp_list[k] ^ KEY);
            end
        end
        d.beats = n;
        d.wr    = w ? n : 0;
        d.busy  = busy;
        d.lat   = n + 1 + busy + stall;
        exp_done.push_back(d);
        @(posedge hclk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_burst = b;
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge hclk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_msg("cmd_accept_timeout", "no cmd_ready", "cmd_ready");
        @(posedge hclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int t = 0; t < 200; t++) begin
            @(negedge hclk);
            if (done_cnt != start) break;
        end
        if (done_cnt == start) fail_msg("rsp_done_timeout", "none", "pulse");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        repeat (3) @(negedge hclk);
        chk("reset_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("reset_hsel", 32'(hsel), 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_hwdata", hwdata, 32'd0);
        hreset = 1'b0;
        @(negedge hclk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_htrans", 32'(htrans), 32'(HTRANS_IDLE));

        // SINGLE write
        exp_list = '{32'h10};
        wd_list  = '{32'hDEADBEEF};
        issue(1'b1, 32'h10, HBURST_SINGLE, HBURST_SINGLE, 0, 0);
        wait_done();

        // INCR4 read
        exp_list = '{32'h100, 32'h104, 32'h108, 32'h10C};
        issue(1'b0, 32'h100, HBURST_INCR4, HBURST_INCR4, 0, 0);
        wait_done();

        // WRAP4 write
        exp_list = '{32'h38, 32'h3C, 32'h30, 32'h34};
        wd_list  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        issue(1'b1, 32'h38, HBURST_WRAP4, HBURST_WRAP4, 0, 0);
        wait_done();

        // WRAP16 read
        exp_list = '{32'h7C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58,
                     32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78};
        issue(1'b0, 32'h7C, HBURST_WRAP16, HBURST_WRAP16, 0, 0);
        wait_done();

        // INCR8 write with two wait states on beat 3
        exp_list = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
        wd_list  = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004,
                     32'hA0A0_0005, 32'hA0A0_0006, 32'hA0A0_0007, 32'hA0A0_0008};
        stall_beat = 2;
        stall_len  = 2;
        issue(1'b1, 32'h200, HBURST_INCR8, HBURST_INCR8, 0, 2);
        wait_done();

        // INCR4 write with a write-data gap before beat 2
        exp_list = '{32'h300, 32'h304, 32'h308, 32'h30C};
        wd_list  = '{32'hB0B0_0001, 32'hB0B0_0002, 32'hB0B0_0003, 32'hB0B0_0004};
        gap_beat = 1;
        issue(1'b1, 32'h300, HBURST_INCR4, HBURST_INCR4, 1, 0);
        wait_done();

        // Undefined-length INCR goes out as SINGLE; unaligned low bits dropped
        exp_list = '{32'h500};
        issue(1'b0, 32'h503, HBURST_INCR, HBURST_SINGLE, 0, 0);
        wait_done();

        // Reset mid-burst
        exp_list = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C};
        issue(1'b0, 32'h400, HBURST_INCR8, HBURST_INCR8, 0, 0);
        @(negedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        chk("midreset_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("midreset_hsel", 32'(hsel), 32'd0);
        chk("midreset_haddr", haddr, 32'd0);
        chk("midreset_rdata_valid", 32'(rdata_valid), 32'd0);
        exp_addr.delete();
        exp_done.delete();
        exp_wd.delete();
        exp_rd.delete();
        wq.delete();
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        repeat (3) @(negedge hclk);
        chk("recover_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("recover_htrans", 32'(htrans), 32'(HTRANS_IDLE));

        exp_list = '{32'h44};
        issue(1'b0, 32'h44, HBURST_SINGLE, HBURST_SINGLE, 0, 0);
        wait_done();
        repeat (5) @(negedge hclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
